// File: rtl/chan_readout_sched.sv
// Post-EOS readout sequencer: scans enabled channels in ascending order, one
// request at a time, with per-channel timeout, downstream pause and EOS overrun flag.
`timescale 1ns/1ps
module chan_readout_sched #(
    parameter int CHAN    = 8,
    parameter int SEL_W   = 3,
    parameter int TO_BITS = 16,
    parameter int TIMEOUT = 4000,
    parameter int GAP_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EOS,
    input  logic [CHAN-1:0]  CHAN_EN,
    input  logic [CHAN-1:0]  RODONE_n,
    input  logic             RD_ALLOW,
    output logic [CHAN-1:0]  RD_REQUEST,
    output logic [SEL_W-1:0] SEL,
    output logic             BUSY,
    output logic             SCAN_DONE,
    output logic [CHAN-1:0]  TIMEOUT_ERR,
    output logic             EOS_OVR
);
    // state  | meaning
    // IDLE   | waiting for an EOS rising edge
    // SELECT | latch lowest pending channel into SEL, load timeout timer
    // READ   | request selected channel until done or timeout
    // GAP    | GAP_CYC quiet cycles between channels
    // DONE   | SCAN_DONE high for one cycle, BUSY drops on exit
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_READ   = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int                 GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TO_BITS-1:0] TO_LOAD  = TO_BITS'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYC - 1);

    state_t             state;
    logic               eos_d;
    logic               eos_rise;
    logic [CHAN-1:0]    pend;
    logic [TO_BITS-1:0] timer;
    logic [GAP_W-1:0]   gap_cnt;

    function automatic logic [SEL_W-1:0] lowest_idx(input logic [CHAN-1:0] v);
        lowest_idx = '0;
        for (int i = CHAN - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = SEL_W'(i);
        end
    endfunction

    assign eos_rise = EOS & ~eos_d;

    always_comb begin
        RD_REQUEST = '0;
        if (state == S_READ && RD_ALLOW) RD_REQUEST[SEL] = 1'b1;
    end

    // timer is a down-counter loaded with TIMEOUT-1; terminal count at zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            eos_d       <= 1'b0;
            pend        <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            SEL         <= '0;
            BUSY        <= 1'b0;
            SCAN_DONE   <= 1'b0;
            TIMEOUT_ERR <= '0;
            EOS_OVR     <= 1'b0;
        end else begin
            eos_d     <= EOS;
            SCAN_DONE <= 1'b0;
            if (eos_rise && state != S_IDLE) EOS_OVR <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (eos_rise) begin
                        if (CHAN_EN != '0) begin
                            pend        <= CHAN_EN;
                            TIMEOUT_ERR <= '0;
                            EOS_OVR     <= 1'b0;
                            BUSY        <= 1'b1;
                            state       <= S_SELECT;
                        end else begin
                            SCAN_DONE <= 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    SEL   <= lowest_idx(pend);
                    timer <= TO_LOAD;
                    state <= S_READ;
                end
                S_READ: begin
                    if (!RODONE_n[SEL]) begin
                        pend[SEL] <= 1'b0;
                        gap_cnt   <= GAP_LOAD;
                        state     <= S_GAP;
                    end else if (RD_ALLOW) begin
                        if (timer == '0) begin
                            TIMEOUT_ERR[SEL] <= 1'b1;
                            pend[SEL]        <= 1'b0;
                            gap_cnt          <= GAP_LOAD;
                            state            <= S_GAP;
                        end else begin
                            timer <= timer - TO_BITS'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        if (pend != '0) begin
                            state <= S_SELECT;
                        end else begin
                            SCAN_DONE <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chan_readout_sched.sv
// Scoreboard bench for chan_readout_sched: a scan-level model queues the expected
// channel reads and end-of-scan flags; a monitor pops and compares what the DUT does.
`timescale 1ns/1ps
module tb_chan_readout_sched;
    localparam int CHAN    = 8;
    localparam int SEL_W   = 3;
    localparam int TO_BITS = 16;
    localparam int TIMEOUT = 4000;
    localparam int GAP_CYC = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             EOS = 1'b0;
    logic [CHAN-1:0]  CHAN_EN = '0;
    logic [CHAN-1:0]  RODONE_n = '1;
    logic             RD_ALLOW = 1'b1;
    logic [CHAN-1:0]  RD_REQUEST;
    logic [SEL_W-1:0] SEL;
    logic             BUSY;
    logic             SCAN_DONE;
    logic [CHAN-1:0]  TIMEOUT_ERR;
    logic             EOS_OVR;

    chan_readout_sched #(
        .CHAN(CHAN), .SEL_W(SEL_W), .TO_BITS(TO_BITS), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .EOS(EOS), .CHAN_EN(CHAN_EN), .RODONE_n(RODONE_n),
        .RD_ALLOW(RD_ALLOW), .RD_REQUEST(RD_REQUEST), .SEL(SEL), .BUSY(BUSY),
        .SCAN_DONE(SCAN_DONE), .TIMEOUT_ERR(TIMEOUT_ERR), .EOS_OVR(EOS_OVR)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        bit        is_end;
        int        ch;
        int        cnt;
        logic [7:0] to_m;
        bit        ovr;
        bit        busy;
    } rec_t;

    rec_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         lat[CHAN];          // request cycles a channel needs before done; 0 = never
    int         allow_mode = 0;     // 0: always ready, 1: random pauses, 2: forced pause
    bit         strict = 1'b0;      // ready held high: gap/select lengths are checked
    int         scans_seen = 0;
    int         exp_scans = 0;
    logic [7:0] to_model = '0;
    bit         ovr_model = 1'b0;

    bit mon_open = 1'b0;
    int mon_ch = 0;
    int mon_cnt = 0;
    int mon_zrun = 0;
    bit mon_first = 1'b1;
    bit mon_busy_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic underflow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got empty scoreboard expected a pending record", name);
    endtask

    function automatic int idx(input logic [7:0] v);
        idx = -1;
        for (int i = 0; i < CHAN; i++) if (v[i]) idx = i;
    endfunction

    task automatic close_read();
        rec_t r;
        mon_open = 1'b0;
        if (sb.size() == 0) begin
            underflow("read_underflow");
            return;
        end
        r = sb.pop_front();
        chk("read_not_end", 32'(r.is_end), 32'd0);
        if (!r.is_end) begin
            chk("read_chan", 32'(mon_ch), 32'(r.ch));
            chk("read_len", 32'(mon_cnt), 32'(r.cnt));
        end
    endtask

    // Scan-level model: ascending enabled channels, each lasting min(lat, TIMEOUT) ready cycles.
    task automatic start_scan(input logic [7:0] en, input bit inject);
        rec_t       r;
        logic [7:0] m;
        m = '0;
        for (int c = 0; c < CHAN; c++) begin
            if (en[c]) begin
                r.is_end = 1'b0; r.ch = c; r.to_m = '0; r.ovr = 1'b0; r.busy = 1'b0;
                if (lat[c] != 0 && lat[c] <= TIMEOUT) r.cnt = lat[c];
                else begin
                    r.cnt = TIMEOUT;
                    m[c] = 1'b1;
                end
                sb.push_back(r);
            end
        end
        if (en != '0) begin
            to_model  = m;
            ovr_model = inject;
        end
        r.is_end = 1'b1; r.ch = -1; r.cnt = 0;
        r.to_m = to_model; r.ovr = ovr_model; r.busy = (en != '0);
        sb.push_back(r);
        exp_scans++;

        @(posedge CLK); #1;
        CHAN_EN = en;
        EOS = 1'b1;
        @(posedge CLK); #1;
        EOS = 1'b0;
        CHAN_EN = 8'($urandom);
        if (inject && en != '0) begin
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1 EOS = 1'b1;
            @(posedge CLK); #1;
            EOS = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && scans_seen < exp_scans; i++) @(negedge CLK);
        if (scans_seen < exp_scans) begin
            checks++;
            errors++;
            $display("FAIL scan_done_wait: got %0d scans expected %0d", scans_seen, exp_scans);
            scans_seen = exp_scans;
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {RD_REQUEST, 5'(SEL), BUSY, SCAN_DONE, TIMEOUT_ERR, EOS_OVR}, 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge CLK); #1;
            case (allow_mode)
                0:       RD_ALLOW = 1'b1;
                1:       RD_ALLOW = ($urandom_range(0, 3) != 0);
                default: RD_ALLOW = 1'b0;
            endcase
        end
    end

    // Channel model: selected channel reports done on its lat-th requested cycle;
    // every unselected channel toggles RODONE_n randomly.
    initial begin
        int         rch;
        int         rcnt;
        int         ch;
        logic [7:0] nv;
        rch = -1;
        rcnt = 0;
        forever begin
            @(negedge CLK);
            if (!BUSY) rch = -1;
            nv = 8'($urandom);
            if (BUSY) nv[SEL] = 1'b1;
            if (RD_REQUEST != '0) begin
                ch = idx(RD_REQUEST);
                if (ch != rch) begin
                    rch = ch;
                    rcnt = 0;
                end
                rcnt++;
                if (lat[ch] != 0 && rcnt == lat[ch]) nv[ch] = 1'b0;
            end
            RODONE_n = nv;
        end
    end

    initial begin
        rec_t r;
        int   c;
        forever begin
            @(negedge CLK);
            if (RST) begin
                mon_open = 1'b0; mon_zrun = 0; mon_first = 1'b1; mon_busy_chk = 1'b0;
                continue;
            end
            if (mon_busy_chk) begin
                chk("busy_after_done", 32'(BUSY), 32'd0);
                mon_busy_chk = 1'b0;
            end
            if (BUSY && !RD_ALLOW) chk("req_paused", 32'(RD_REQUEST), 32'd0);
            if (RD_REQUEST != '0) begin
                chk("req_onehot", 32'($countones(RD_REQUEST)), 32'd1);
                c = idx(RD_REQUEST);
                if (mon_open && c != mon_ch) close_read();
                if (!mon_open) begin
                    mon_open = 1'b1; mon_ch = c; mon_cnt = 0;
                    if (strict) begin
                        if (mon_first) chk("select_len", 32'(mon_zrun), 32'd1);
                        else           chk("gap_len", 32'(mon_zrun), 32'(GAP_CYC + 1));
                    end
                    mon_first = 1'b0;
                    if (sb.size() > 0) chk("sel_value", 32'(SEL), 32'(sb[0].ch));
                end
                mon_cnt++;
                mon_zrun = 0;
            end else if (BUSY) begin
                if (mon_open && RD_ALLOW) close_read();
                mon_zrun++;
            end
            if (SCAN_DONE) begin
                if (mon_open) close_read();
                if (sb.size() == 0) underflow("end_underflow");
                else begin
                    r = sb.pop_front();
                    chk("end_is_end", 32'(r.is_end), 32'd1);
                    chk("timeout_err", 32'(TIMEOUT_ERR), 32'(r.to_m));
                    chk("eos_ovr", 32'(EOS_OVR), 32'(r.ovr));
                    chk("busy_at_done", 32'(BUSY), 32'(r.busy));
                    if (strict && r.busy) chk("done_gap", 32'(mon_zrun), 32'(GAP_CYC + 1));
                end
                scans_seen++;
                mon_zrun = 0;
                mon_first = 1'b1;
                mon_busy_chk = 1'b1;
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got no finish expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < CHAN; c++) lat[c] = 5;
        #2 RST = 1'b1;
        #2 check_all_zero("reset_state");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("idle_after_reset");

        // full scan, fixed 5-cycle latency
        allow_mode = 0; strict = 1'b1;
        start_scan(8'hFF, 1'b0);
        wait_done(2000);

        // sparse mask
        for (int c = 0; c < CHAN; c++) lat[c] = $urandom_range(1, 12);
        start_scan(8'b1010_0100, 1'b0);
        wait_done(2000);

        // stuck channel 3 plus an overrun EOS
        for (int c = 0; c < CHAN; c++) lat[c] = 5;
        lat[3] = 0;
        start_scan(8'h0F, 1'b1);
        wait_done(TIMEOUT + 2000);

        // empty mask leaves sticky flags alone; next real scan clears them
        start_scan(8'h00, 1'b0);
        wait_done(100);
        lat[3] = 5;
        start_scan(8'h01, 1'b0);
        wait_done(200);

        // done exactly at the timeout cycle wins; one cycle later loses
        lat[1] = TIMEOUT;
        lat[2] = TIMEOUT + 1;
        start_scan(8'h06, 1'b0);
        wait_done(2 * TIMEOUT + 200);

        // long downstream pause during the ch1 read must freeze its timer
        strict = 1'b0;
        lat[0] = 3;
        lat[1] = TIMEOUT - 50;
        start_scan(8'h03, 1'b0);
        for (int i = 0; i < 200 && RD_REQUEST[1] !== 1'b1; i++) @(negedge CLK);
        repeat (50) @(negedge CLK);
        allow_mode = 2;
        repeat (100) @(negedge CLK);
        allow_mode = 0;
        wait_done(TIMEOUT + 500);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] en;
            bit         inj;
            en = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            for (int c = 0; c < CHAN; c++) lat[c] = $urandom_range(1, 12);
            allow_mode = $urandom_range(0, 1);
            strict = (allow_mode == 0);
            inj = (en != '0) && ($urandom_range(0, 2) == 0);
            start_scan(en, inj);
            wait_done(5000);
        end
        allow_mode = 0;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        // asynchronous reset in the middle of a scan
        for (int c = 0; c < CHAN; c++) lat[c] = 6;
        strict = 1'b0;
        start_scan(8'hF0, 1'b1);
        repeat (4) @(negedge CLK);
        #3 RST = 1'b1;
        #1 check_all_zero("reset_mid_scan");
        sb.delete();
        exp_scans = scans_seen;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_all_zero("idle_after_mid_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
